decode_stage: RTL and testbench

Instruction-decode stage of the in-order pipeline, between the IF/ID register and the execute stage. Extracts register and immediate fields and reads the register file, with write-back bypass. Sends the opcode to `main_controller` and latches its `rs2_imm_sel`/`reg_w_en` response. Stalls on register hazards using a busy-bit scoreboard, then registers everything into the ID/EX pipeline register under a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/reg_file.sv | 38 +++
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcodes, instruction field positions
// and the ID/EX pipeline register layout.
package cpu_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 1 << REG_AW;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int IMM_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic              rs2_imm_sel;
        logic              reg_w_en;
    } idex_t;

    function automatic logic [XLEN-1:0] sext_imm12(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[IMM_LSB +: 12]};
    endfunction
endpackage

// File: rtl/reg_file.sv
// Register file: two read ports, one write port, x0 hardwired to zero,
// synchronous active-low clear and same-cycle write-through to the readers.
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);
    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    always_comb begin
        rdata1 = mem_q[raddr1];
        rdata2 = mem_q[raddr2];
        if (we && waddr != '0 && waddr == raddr1) rdata1 = wdata;
        if (we && waddr != '0 && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end
endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field extraction, register read with write-back bypass,
// busy-bit scoreboard hazard stall, and the ID/EX valid/ready pipeline register.
module decode_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    output logic [6:0]        ctrl_opcode,
    input  logic              ctrl_rs2_imm_sel,
    input  logic              ctrl_reg_w_en,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_rs2_imm_sel,
    output logic              ex_reg_w_en
);
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   rs1_data, rs2_data;
    logic [NREG-1:0]   busy_q, busy_d, wb_clr, eff_busy;
    logic              hazard, accept;
    idex_t             idex_q, idex_d;

    assign rs1         = if_instr[RS1_LSB +: REG_AW];
    assign rs2         = if_instr[RS2_LSB +: REG_AW];
    assign rd          = if_instr[RD_LSB +: REG_AW];
    assign ctrl_opcode = if_instr[OPC_LSB +: 7];

    reg_file u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    // A register being written back this cycle no longer blocks its readers.
    always_comb begin
        wb_clr = '0;
        if (wb_en) wb_clr[wb_rd] = 1'b1;
        eff_busy = busy_q & ~wb_clr;
        hazard = ctrl_reg_w_en &&
                 (eff_busy[rs1] || eff_busy[rd] || (!ctrl_rs2_imm_sel && eff_busy[rs2]));
    end

    assign id_ready = rst_n && !flush && !hazard && (!idex_q.valid || ex_ready);
    assign accept   = if_valid && id_ready;

    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (flush && idex_q.valid && idex_q.reg_w_en)
            busy_d[idex_q.rd] = 1'b0;
        if (accept && ctrl_reg_w_en)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d.valid = 1'b0;
        end else if (id_ready) begin
            idex_d.valid       = if_valid;
            idex_d.pc          = if_pc;
            idex_d.rs1_data    = rs1_data;
            idex_d.rs2_data    = rs2_data;
            idex_d.imm         = sext_imm12(if_instr);
            idex_d.rd          = rd;
            idex_d.funct3      = if_instr[F3_LSB +: 3];
            idex_d.funct7      = if_instr[F7_LSB +: 7];
            idex_d.rs2_imm_sel = ctrl_rs2_imm_sel;
            idex_d.reg_w_en    = ctrl_reg_w_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            idex_q <= '0;
        end else begin
            busy_q <= busy_d;
            idex_q <= idex_d;
        end
    end

    assign ex_valid       = idex_q.valid;
    assign ex_pc          = idex_q.pc;
    assign ex_rs1_data    = idex_q.rs1_data;
    assign ex_rs2_data    = idex_q.rs2_data;
    assign ex_imm         = idex_q.imm;
    assign ex_rd          = idex_q.rd;
    assign ex_funct3      = idex_q.funct3;
    assign ex_funct7      = idex_q.funct7;
    assign ex_rs2_imm_sel = idex_q.rs2_imm_sel;
    assign ex_reg_w_en    = idex_q.reg_w_en;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table for the multi-cycle scenarios,
// then random traffic checked against a register/scoreboard reference model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, if_valid, id_ready, ctrl_rs2_imm_sel, ctrl_reg_w_en;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [6:0]  ctrl_opcode;
    logic        wb_en, flush, ex_ready, ex_valid, ex_rs2_imm_sel, ex_reg_w_en;
    logic [4:0]  wb_rd, ex_rd;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .ctrl_opcode(ctrl_opcode),
        .ctrl_rs2_imm_sel(ctrl_rs2_imm_sel), .ctrl_reg_w_en(ctrl_reg_w_en),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_rs2_imm_sel(ex_rs2_imm_sel), .ex_reg_w_en(ex_reg_w_en)
    );

    // Stand-in for main_controller, driven from the opcode the stage presents.
    always_comb begin
        ctrl_rs2_imm_sel = 1'b0;
        ctrl_reg_w_en    = 1'b0;
        if (ctrl_opcode == 7'b0110011) begin
            ctrl_reg_w_en = 1'b1;
        end else if (ctrl_opcode == 7'b0010011) begin
            ctrl_rs2_imm_sel = 1'b1;
            ctrl_reg_w_en    = 1'b1;
        end
    end

    // Reference model state
    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          sel, wen;
    } mex_t;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    mex_t        m_ex;

    typedef struct {
        bit          rst_n, vld;
        logic [31:0] instr;
        bit          wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        bit          flush, ex_rdy;
        bit          exp_rdy, exp_vld;
        logic [4:0]  exp_rd;
        logic [31:0] exp_imm, exp_rs1;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_ctrl(input logic [31:0] ins, output bit sel, output bit wen);
        sel = (ins[6:0] == 7'b0010011);
        wen = (ins[6:0] == 7'b0010011) || (ins[6:0] == 7'b0110011);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_ready();
        bit eb [32];
        bit sel, wen, haz;
        if (!rst_n) return 1'b0;
        eb = m_busy;
        if (wb_en) eb[wb_rd] = 1'b0;
        m_ctrl(if_instr, sel, wen);
        haz = wen && (eb[if_instr[19:15]] || eb[if_instr[11:7]] || (!sel && eb[if_instr[24:20]]));
        return !flush && !haz && (!m_ex.valid || ex_ready);
    endfunction

    task automatic m_clock();
        bit rdy, sel, wen;
        mex_t nx;
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ex = '{default: 0};
            return;
        end
        rdy = m_ready();
        m_ctrl(if_instr, sel, wen);
        nx = m_ex;
        if (flush) begin
            nx.valid = 1'b0;
        end else if (rdy) begin
            nx.valid = if_valid;
            nx.pc    = if_pc;
            nx.rs1   = m_read(if_instr[19:15]);
            nx.rs2   = m_read(if_instr[24:20]);
            nx.imm   = 32'($signed(if_instr[31:20]));
            nx.rd    = if_instr[11:7];
            nx.f3    = if_instr[14:12];
            nx.f7    = if_instr[31:25];
            nx.sel   = sel;
            nx.wen   = wen;
        end
        if (wb_en) m_busy[wb_rd] = 1'b0;
        if (flush && m_ex.valid && m_ex.wen) m_busy[m_ex.rd] = 1'b0;
        if (if_valid && rdy && wen && if_instr[11:7] != 0) m_busy[if_instr[11:7]] = 1'b1;
        m_busy[0] = 1'b0;
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        m_ex = nx;
    endtask

    // One cycle: drive at the falling edge, check id_ready, clock, check ID/EX.
    task automatic run_cycle(input vec_t v, input bit use_tbl);
        rst_n    = v.rst_n;
        if_valid = v.vld;
        if_instr = v.instr;
        if_pc    = $urandom;
        wb_en    = v.wb_en;
        wb_rd    = v.wb_rd;
        wb_data  = v.wb_data;
        flush    = v.flush;
        ex_ready = v.ex_rdy;
        #1;
        chk("id_ready", {31'd0, id_ready}, {31'd0, m_ready()});
        chk("ctrl_opcode", {25'd0, ctrl_opcode}, {25'd0, v.instr[6:0]});
        if (use_tbl) chk("tbl_id_ready", {31'd0, id_ready}, {31'd0, v.exp_rdy});
        m_clock();
        @(posedge clk);
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex.valid});
        chk("ex_pc", ex_pc, m_ex.pc);
        chk("ex_rs1_data", ex_rs1_data, m_ex.rs1);
        chk("ex_rs2_data", ex_rs2_data, m_ex.rs2);
        chk("ex_imm", ex_imm, m_ex.imm);
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_ex.rd});
        chk("ex_funct3", {29'd0, ex_funct3}, {29'd0, m_ex.f3});
        chk("ex_funct7", {25'd0, ex_funct7}, {25'd0, m_ex.f7});
        chk("ex_rs2_imm_sel", {31'd0, ex_rs2_imm_sel}, {31'd0, m_ex.sel});
        chk("ex_reg_w_en", {31'd0, ex_reg_w_en}, {31'd0, m_ex.wen});
        if (use_tbl) begin
            chk("tbl_ex_valid", {31'd0, ex_valid}, {31'd0, v.exp_vld});
            chk("tbl_ex_rd", {27'd0, ex_rd}, {27'd0, v.exp_rd});
            chk("tbl_ex_imm", ex_imm, v.exp_imm);
            chk("tbl_ex_rs1_data", ex_rs1_data, v.exp_rs1);
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(input bit r, input bit vl, input logic [31:0] ins,
                                input bit we, input logic [4:0] wr, input logic [31:0] wd,
                                input bit fl, input bit er, input bit erdy, input bit evld,
                                input logic [4:0] erd, input logic [31:0] eimm,
                                input logic [31:0] ers1);
        vec_t v;
        v.rst_n = r;  v.vld = vl;   v.instr = ins;  v.wb_en = we;  v.wb_rd = wr;
        v.wb_data = wd; v.flush = fl; v.ex_rdy = er; v.exp_rdy = erdy; v.exp_vld = evld;
        v.exp_rd = erd; v.exp_imm = eimm; v.exp_rs1 = ers1;
        return v;
    endfunction

    localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADD3  = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] ADDI4 = 32'hFFF00213;  // addi x4,x0,-1
    localparam logic [31:0] ADDI8 = 32'h00000413;  // addi x8,x0,0
    localparam logic [31:0] ADDI9 = 32'h00000493;  // addi x9,x0,0
    localparam logic [31:0] ADDI5 = 32'h00900293;  // addi x5,x0,9
    localparam logic [31:0] ADD6  = 32'h00028333;  // add  x6,x5,x0
    localparam logic [31:0] ADD7  = 32'h000303B3;  // add  x7,x6,x0

    initial begin
        vec_t rv;
        logic [31:0] ins;
        int k;
        tbl[0]  = mk(0, 1, ADDI1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, ADDI1, 0, 0, 0, 0, 1,  1, 1, 1, 5, 0);
        tbl[2]  = mk(1, 1, ADD3,  0, 0, 0, 0, 1,  0, 1, 1, 5, 0);
        tbl[3]  = mk(1, 1, ADD3,  0, 0, 0, 0, 1,  0, 1, 1, 5, 0);
        tbl[4]  = mk(1, 1, ADD3,  1, 1, 5, 0, 1,  1, 1, 3, 2, 5);
        tbl[5]  = mk(1, 1, ADDI4, 0, 0, 0, 0, 0,  0, 1, 3, 2, 5);
        tbl[6]  = mk(1, 1, ADDI4, 0, 0, 0, 0, 0,  0, 1, 3, 2, 5);
        tbl[7]  = mk(1, 1, ADDI4, 0, 0, 0, 0, 0,  0, 1, 3, 2, 5);
        tbl[8]  = mk(1, 1, ADDI4, 0, 0, 0, 0, 1,  1, 1, 4, 32'hFFFFFFFF, 0);
        tbl[9]  = mk(1, 1, ADDI8, 1, 0, 7, 0, 1,  1, 1, 8, 0, 0);
        tbl[10] = mk(1, 1, ADDI9, 0, 0, 0, 0, 1,  1, 1, 9, 0, 0);
        tbl[11] = mk(1, 1, ADDI5, 0, 0, 0, 0, 1,  1, 1, 5, 9, 0);
        tbl[12] = mk(1, 1, ADD6,  0, 0, 0, 1, 1,  0, 0, 5, 9, 0);
        tbl[13] = mk(1, 1, ADD6,  0, 0, 0, 0, 1,  1, 1, 6, 0, 0);
        tbl[14] = mk(1, 1, ADD7,  0, 0, 0, 0, 1,  0, 1, 6, 0, 0);
        tbl[15] = mk(0, 1, ADD7,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        tbl[16] = mk(1, 1, ADD7,  0, 0, 0, 0, 1,  1, 1, 7, 0, 0);
        tbl[17] = mk(1, 0, 32'h0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);

        foreach (m_regs[i]) m_regs[i] = 32'd0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ex = '{default: 0};
        @(negedge clk);

        for (int i = 0; i < 18; i++) run_cycle(tbl[i], 1'b1);

        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            ins[24:23] = 2'b00;
            ins[19:18] = 2'b00;
            ins[11:10] = 2'b00;
            k = $urandom_range(0, 9);
            ins[6:0] = (k < 4) ? 7'b0110011 : (k < 8) ? 7'b0010011 : 7'b0000011;
            rv = mk(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), ins,
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    0, 0, 0, 0, 0);
            run_cycle(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
